// File: rtl/ps2_key_decoder.sv
// ps2_key_decoder: pops PS/2 set-2 bytes from the receiver FIFO and decodes make/break/E0 sequences
// into a single held key with ASCII translation, a press counter and a sticky overflow flag.
module ps2_key_decoder #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic [7:0]       kb_data,
    input  logic             kb_ready,
    input  logic             kb_overflow,
    output logic             kb_nextdata_n,
    output logic             key_valid,
    output logic [7:0]       key_code,
    output logic             key_ext,
    output logic [7:0]       key_ascii,
    output logic [CNT_W-1:0] press_cnt,
    output logic             overflow_seen
);
    typedef enum logic [1:0] {IDLE, POP, WAIT} state_t;
    state_t r_state, w_next;
    logic             r_nextdata_n, r_key_valid, r_key_ext, r_e0_pend, r_f0_pend, r_ovf;
    logic [7:0]       r_byte, r_key_code, r_key_ascii, w_map, w_ascii;
    logic [CNT_W-1:0] r_press_cnt;
    logic             w_pop, w_prefix, w_match, w_make, w_break, w_data;
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) r_state <= IDLE;
        else         r_state <= w_next;
    end
    always_comb begin
        w_next   = r_state;
        w_next   = (r_state == IDLE) ? (kb_ready ? POP : IDLE) : (r_state == POP) ? WAIT : IDLE;
        w_pop    = (r_state == POP);
        w_prefix = (r_byte == 8'hE0) || (r_byte == 8'hF0);
        w_match  = r_key_valid && (r_key_code == r_byte) && (r_key_ext == r_e0_pend);
        w_data   = w_pop && !w_prefix;
        w_make   = w_data && !r_f0_pend && !w_match;
        w_break  = w_data && r_f0_pend && w_match;
        w_ascii  = r_e0_pend ? 8'h00 : w_map;
    end
    always_comb begin
        w_map = 8'h00;
        case (r_byte)
            8'h1C: w_map = 8'h61; 8'h32: w_map = 8'h62; 8'h21: w_map = 8'h63; 8'h23: w_map = 8'h64;
            8'h24: w_map = 8'h65; 8'h2B: w_map = 8'h66; 8'h34: w_map = 8'h67; 8'h33: w_map = 8'h68;
            8'h43: w_map = 8'h69; 8'h3B: w_map = 8'h6A; 8'h42: w_map = 8'h6B; 8'h4B: w_map = 8'h6C;
            8'h3A: w_map = 8'h6D; 8'h31: w_map = 8'h6E; 8'h44: w_map = 8'h6F; 8'h4D: w_map = 8'h70;
            8'h15: w_map = 8'h71; 8'h2D: w_map = 8'h72; 8'h1B: w_map = 8'h73; 8'h2C: w_map = 8'h74;
            8'h3C: w_map = 8'h75; 8'h2A: w_map = 8'h76; 8'h1D: w_map = 8'h77; 8'h22: w_map = 8'h78;
            8'h35: w_map = 8'h79; 8'h1A: w_map = 8'h7A;
            8'h45: w_map = 8'h30; 8'h16: w_map = 8'h31; 8'h1E: w_map = 8'h32; 8'h26: w_map = 8'h33;
            8'h25: w_map = 8'h34; 8'h2E: w_map = 8'h35; 8'h36: w_map = 8'h36; 8'h3D: w_map = 8'h37;
            8'h3E: w_map = 8'h38; 8'h46: w_map = 8'h39;
            8'h29: w_map = 8'h20; 8'h5A: w_map = 8'h0D;
            default: w_map = 8'h00;
        endcase
    end
    // Pop strobe is registered from the next state so it is low exactly while in POP.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_nextdata_n <= 1'b1;
            r_byte       <= 8'h00;
            r_key_valid  <= 1'b0;
            r_key_code   <= 8'h00;
            r_key_ext    <= 1'b0;
            r_key_ascii  <= 8'h00;
            r_press_cnt  <= '0;
            r_e0_pend    <= 1'b0;
            r_f0_pend    <= 1'b0;
            r_ovf        <= 1'b0;
        end else begin
            r_nextdata_n <= (w_next != POP);
            if (r_state == IDLE && kb_ready) r_byte <= kb_data;
            if (kb_overflow) r_ovf <= 1'b1;
            if (w_pop && r_byte == 8'hE0) r_e0_pend <= 1'b1;
            if (w_pop && r_byte == 8'hF0) r_f0_pend <= 1'b1;
            if (w_data) begin
                r_e0_pend <= 1'b0;
                r_f0_pend <= 1'b0;
            end
            if (w_make) begin
                r_key_valid <= 1'b1;
                r_key_code  <= r_byte;
                r_key_ext   <= r_e0_pend;
                r_key_ascii <= w_ascii;
                r_press_cnt <= r_press_cnt + CNT_W'(1);
            end
            if (w_break) r_key_valid <= 1'b0;
        end
    end
    assign kb_nextdata_n = r_nextdata_n;
    assign key_valid     = r_key_valid;
    assign key_code      = r_key_code;
    assign key_ext       = r_key_ext;
    assign key_ascii     = r_key_ascii;
    assign press_cnt     = r_press_cnt;
    assign overflow_seen = r_ovf;
endmodule

// File: tb/tb_ps2_key_decoder.sv
// tb_ps2_key_decoder: FIFO model feeds directed byte sequences; a scoreboard checks decoder
// outputs one cycle after every pop strobe against hand-computed expectations.
module tb_ps2_key_decoder;
    logic       clk = 1'b0;
    logic       resetn;
    logic [7:0] kb_data;
    logic       kb_ready;
    logic       kb_overflow;
    logic       kb_nextdata_n, key_valid, key_ext, overflow_seen;
    logic [7:0] key_code, key_ascii, press_cnt;

    typedef struct {
        logic       v;
        logic [7:0] code;
        logic       ext;
        logic [7:0] ascii;
        logic [7:0] cnt;
    } exp_t;

    logic [7:0] fifo[$];
    exp_t       exq[$];
    int         pop_q[$];
    int         rd = 0, sb_rd = 0, cyc = 0, n_cmp = 0, n_bad = 0, base = 0, t = 0;
    logic       chk_pend = 1'b0;
    exp_t       e;

    ps2_key_decoder #(.CNT_W(8)) dut (
        .clk(clk), .resetn(resetn), .kb_data(kb_data), .kb_ready(kb_ready),
        .kb_overflow(kb_overflow), .kb_nextdata_n(kb_nextdata_n), .key_valid(key_valid),
        .key_code(key_code), .key_ext(key_ext), .key_ascii(key_ascii),
        .press_cnt(press_cnt), .overflow_seen(overflow_seen)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
        n_cmp++;
        if (act !== want) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, want, cyc);
        end
    endtask

    task automatic feed(input logic [7:0] b, input logic v, input logic [7:0] c,
                        input logic x, input logic [7:0] a, input logic [7:0] n);
        fifo.push_back(b);
        exq.push_back('{v, c, x, a, n});
    endtask

    task automatic chk_rst();
        chk("rst_nextdata_n", kb_nextdata_n, 1);
        chk("rst_key_valid", key_valid, 0);
        chk("rst_key_code", key_code, 0);
        chk("rst_key_ext", key_ext, 0);
        chk("rst_key_ascii", key_ascii, 0);
        chk("rst_press_cnt", press_cnt, 0);
        chk("rst_overflow_seen", overflow_seen, 0);
    endtask

    task automatic do_reset();
        @(posedge clk); #1 resetn = 1'b0;
        repeat (2) @(posedge clk);
        #1 chk_rst();
        resetn = 1'b1;
    endtask

    task automatic drain();
        int k;
        for (k = 0; k < 5000; k++) begin
            @(posedge clk);
            if (rd == fifo.size() && sb_rd == exq.size() && kb_nextdata_n === 1'b1 && !chk_pend && !kb_ready) break;
        end
        if (k == 5000) chk("drain_timeout", 1, 0);
        @(posedge clk);
    endtask

    initial begin
        resetn = 1'b0; kb_ready = 1'b0; kb_data = 8'h00; kb_overflow = 1'b0;
        fork
            forever begin
                @(negedge clk);
                cyc++;
                if (!resetn) begin
                    chk_pend = 1'b0;
                    rd = fifo.size();
                end else begin
                    if (chk_pend) begin
                        if (sb_rd >= exq.size()) chk("sb_unexpected_pop", 1, 0);
                        else begin
                            e = exq[sb_rd];
                            sb_rd++;
                            chk("key_valid", key_valid, e.v);
                            chk("key_code", key_code, e.code);
                            chk("key_ext", key_ext, e.ext);
                            chk("key_ascii", key_ascii, e.ascii);
                            chk("press_cnt", press_cnt, e.cnt);
                        end
                    end
                    if (!kb_nextdata_n) begin
                        chk("nextdata_consecutive", chk_pend, 0);
                        pop_q.push_back(cyc);
                        rd++;
                    end
                    chk_pend = !kb_nextdata_n;
                end
                kb_ready = rd < fifo.size();
                kb_data  = kb_ready ? fifo[rd] : 8'h00;
            end
            begin
                repeat (2) @(posedge clk);
                #1 chk_rst();
                resetn = 1'b1;
                // press/release 'a', then Enter and '0' where the newer key replaces the older
                feed(8'h1C, 1, 8'h1C, 0, 8'h61, 1);
                feed(8'hF0, 1, 8'h1C, 0, 8'h61, 1);
                feed(8'h1C, 0, 8'h1C, 0, 8'h61, 1);
                feed(8'h5A, 1, 8'h5A, 0, 8'h0D, 2);
                feed(8'h45, 1, 8'h45, 0, 8'h30, 3);
                feed(8'hF0, 1, 8'h45, 0, 8'h30, 3);
                feed(8'h5A, 1, 8'h45, 0, 8'h30, 3);
                feed(8'hF0, 1, 8'h45, 0, 8'h30, 3);
                feed(8'h45, 0, 8'h45, 0, 8'h30, 3);
                drain();
                do_reset();
                for (int i = 0; i < 3; i++) feed(8'h16, 1, 8'h16, 0, 8'h31, 1);
                feed(8'hF0, 1, 8'h16, 0, 8'h31, 1);
                feed(8'h16, 0, 8'h16, 0, 8'h31, 1);
                drain();
                do_reset();
                feed(8'hE0, 0, 8'h00, 0, 8'h00, 0);
                feed(8'h75, 1, 8'h75, 1, 8'h00, 1);
                feed(8'hF0, 1, 8'h75, 1, 8'h00, 1);
                feed(8'h75, 1, 8'h75, 1, 8'h00, 1);
                feed(8'hE0, 1, 8'h75, 1, 8'h00, 1);
                feed(8'hF0, 1, 8'h75, 1, 8'h00, 1);
                feed(8'h75, 0, 8'h75, 1, 8'h00, 1);
                feed(8'hE0, 0, 8'h75, 1, 8'h00, 1);
                feed(8'h1C, 1, 8'h1C, 1, 8'h00, 2);
                feed(8'h1C, 1, 8'h1C, 0, 8'h61, 3);
                drain();
                do_reset();
                for (int i = 0; i < 256; i++) begin
                    feed(8'h29, 1, 8'h29, 0, 8'h20, 8'(i + 1));
                    feed(8'hF0, 1, 8'h29, 0, 8'h20, 8'(i + 1));
                    feed(8'h29, 0, 8'h29, 0, 8'h20, 8'(i + 1));
                end
                drain();
                chk("wrap_press_cnt", press_cnt, 0);
                do_reset();
                base = pop_q.size();
                feed(8'h24, 1, 8'h24, 0, 8'h65, 1);
                feed(8'hF0, 1, 8'h24, 0, 8'h65, 1);
                feed(8'h24, 0, 8'h24, 0, 8'h65, 1);
                drain();
                chk("pop_count", pop_q.size() - base, 3);
                if (pop_q.size() - base >= 3) begin
                    chk("pop_gap1", pop_q[base+1] - pop_q[base], 3);
                    chk("pop_gap2", pop_q[base+2] - pop_q[base+1], 3);
                end
                chk("overflow_before", overflow_seen, 0);
                @(posedge clk); #1 kb_overflow = 1'b1;
                @(posedge clk); #1 kb_overflow = 1'b0;
                chk("overflow_set", overflow_seen, 1);
                repeat (5) @(posedge clk);
                #1 chk("overflow_sticky", overflow_seen, 1);
                do_reset();
                feed(8'hE0, 0, 8'h00, 0, 8'h00, 0);
                drain();
                // a byte caught mid-pop by reset must be dropped along with the pending E0
                fifo.push_back(8'h16);
                for (t = 0; t < 50; t++) begin
                    @(posedge clk); #1;
                    if (!kb_nextdata_n) break;
                end
                if (t == 50) chk("pop_wait_timeout", 1, 0);
                resetn = 1'b0;
                #1 chk("rst_in_pop_nextdata_n", kb_nextdata_n, 1);
                repeat (2) @(posedge clk);
                #1 chk_rst();
                resetn = 1'b1;
                feed(8'h75, 1, 8'h75, 0, 8'h00, 1);
                drain();
                $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
                $finish;
            end
        join_any
    end
endmodule
